// File: rtl/hs_launch_pkg.sv
// Shared types, default sizes and the saturating-increment helper for hs_launcher.
package hs_launch_pkg;

  localparam int unsigned CNT_W_DEF           = 16;
  localparam int unsigned PERF_W_DEF          = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned SAT_W               = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Increment v, holding at the all-ones value of a w-bit field (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    sat_inc = (v >= lim) ? lim : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/hs_launch_perf_counter.sv
// Saturating event counter with synchronous reset, clear and enable.
module hs_perf_counter
  import hs_launch_pkg::*;
#(
  parameter int unsigned W = PERF_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= W'(sat_inc(SAT_W'(count), W));
    end
  end

endmodule

// File: rtl/hs_launcher.sv
// ap_ctrl_hs sequencer: one parent invocation drives a child kernel through N overlapped runs.
// Optional performance counters are built when HS_LAUNCH_PERF_EN is defined.
module hs_launcher
  import hs_launch_pkg::*;
#(
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned PERF_W          = PERF_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [CNT_W-1:0]  num_runs,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              child_ap_start,
  input  logic              child_ap_ready,
  input  logic              child_ap_done,
  output logic              child_ap_continue,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  done_cnt,
  output logic [PERF_W-1:0] perf_busy_cycles,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t             state;
  logic [CNT_W-1:0]   n_runs;
  logic [OUT_W-1:0]   outstanding;
  logic               start_hs;
  logic               done_hs;
  logic [CNT_W-1:0]   issued_nx;
  logic [CNT_W-1:0]   done_nx;
  logic [OUT_W-1:0]   outst_nx;

  // Handshakes of this cycle and the counter values they produce.
  always_comb begin
    start_hs  = child_ap_start && child_ap_ready;
    done_hs   = (state == RUN) && child_ap_done && child_ap_continue && (outstanding != '0);
    issued_nx = start_hs ? CNT_W'(sat_inc(SAT_W'(issued_cnt), CNT_W)) : issued_cnt;
    done_nx   = done_hs ? CNT_W'(sat_inc(SAT_W'(done_cnt), CNT_W)) : done_cnt;
    outst_nx  = outstanding;
    if (start_hs && !done_hs) begin
      outst_nx = outstanding + OUT_W'(1);
    end else if (!start_hs && done_hs) begin
      outst_nx = outstanding - OUT_W'(1);
    end
  end

  // Control FSM; child_ap_start is derived from next-cycle counters so it is a clean flop.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state             <= IDLE;
      n_runs            <= '0;
      outstanding       <= '0;
      issued_cnt        <= '0;
      done_cnt          <= '0;
      ap_idle           <= 1'b1;
      ap_done           <= 1'b0;
      ap_ready          <= 1'b0;
      child_ap_start    <= 1'b0;
      child_ap_continue <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state             <= RUN;
            n_runs            <= num_runs;
            outstanding       <= '0;
            issued_cnt        <= '0;
            done_cnt          <= '0;
            ap_idle           <= 1'b0;
            child_ap_continue <= 1'b1;
            child_ap_start    <= (num_runs != '0);
          end
        end
        RUN: begin
          issued_cnt  <= issued_nx;
          done_cnt    <= done_nx;
          outstanding <= outst_nx;
          // A zero-run request leaves here after its single pass-through cycle.
          if (done_nx == n_runs) begin
            state             <= FIN;
            child_ap_start    <= 1'b0;
            child_ap_continue <= 1'b0;
            ap_done           <= 1'b1;
            ap_ready          <= 1'b1;
          end else begin
            child_ap_start <= (issued_nx < n_runs) &&
                              (outst_nx < OUT_W'(MAX_OUTSTANDING));
          end
        end
        FIN: begin
          state    <= IDLE;
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
        end
        default: begin
          state             <= IDLE;
          ap_idle           <= 1'b1;
          ap_done           <= 1'b0;
          ap_ready          <= 1'b0;
          child_ap_start    <= 1'b0;
          child_ap_continue <= 1'b0;
        end
      endcase
    end
  end

`ifdef HS_LAUNCH_PERF_EN
  hs_perf_counter #(.W(PERF_W)) u_busy (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .clr   ((state == IDLE) && ap_start),
    .en    (state == RUN),
    .count (perf_busy_cycles)
  );

  hs_perf_counter #(.W(PERF_W)) u_stall (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .clr   ((state == IDLE) && ap_start),
    .en    (child_ap_start && !child_ap_ready),
    .count (perf_stall_cycles)
  );
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hs_launcher.sv
// Bench for hs_launcher: directed table, hand sequences and random traffic on a
// MAX_OUTSTANDING=4 and a MAX_OUTSTANDING=1 instance against a counting model.
module tb_hs_launcher;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 32;

  logic          ap_clk;
  logic          ap_rst;
  logic          ap_start;
  logic [CW-1:0] num_runs;
  logic          c_ready;
  logic          c_done;
  int            sel;

  logic          start_a, start_b;
  logic          ready_a, done_a, idle_a, cstart_a, cont_a;
  logic          ready_b, done_b, idle_b, cstart_b, cont_b;
  logic [CW-1:0] iss_a, dcnt_a, iss_b, dcnt_b;
  logic [PW-1:0] busy_a, stall_a, busy_b, stall_b;

  logic          o_ready, o_done, o_idle, o_cstart, o_cont;
  logic [CW-1:0] o_issued, o_donec;
  logic [PW-1:0] o_busy, o_stall;

  assign start_a = ap_start && (sel == 0);
  assign start_b = ap_start && (sel == 1);

  hs_launcher #(.CNT_W(CW), .MAX_OUTSTANDING(4), .PERF_W(PW)) dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_a), .num_runs(num_runs),
    .ap_ready(ready_a), .ap_done(done_a), .ap_idle(idle_a),
    .child_ap_start(cstart_a), .child_ap_ready(c_ready), .child_ap_done(c_done),
    .child_ap_continue(cont_a), .issued_cnt(iss_a), .done_cnt(dcnt_a),
    .perf_busy_cycles(busy_a), .perf_stall_cycles(stall_a)
  );

  hs_launcher #(.CNT_W(CW), .MAX_OUTSTANDING(1), .PERF_W(PW)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_b), .num_runs(num_runs),
    .ap_ready(ready_b), .ap_done(done_b), .ap_idle(idle_b),
    .child_ap_start(cstart_b), .child_ap_ready(c_ready), .child_ap_done(c_done),
    .child_ap_continue(cont_b), .issued_cnt(iss_b), .done_cnt(dcnt_b),
    .perf_busy_cycles(busy_b), .perf_stall_cycles(stall_b)
  );

  always_comb begin
    if (sel == 1) begin
      o_ready = ready_b; o_done = done_b; o_idle = idle_b; o_cstart = cstart_b;
      o_cont = cont_b; o_issued = iss_b; o_donec = dcnt_b; o_busy = busy_b; o_stall = stall_b;
    end else begin
      o_ready = ready_a; o_done = done_a; o_idle = idle_a; o_cstart = cstart_a;
      o_cont = cont_a; o_issued = iss_a; o_donec = dcnt_a; o_busy = busy_a; o_stall = stall_a;
    end
  end

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad = 0;

  // Model: phase 0 waiting, 1 launching, 2 reporting; q holds issue cycles of open runs.
  int ph, mn, iss, dc, busy, stall, mx, cyc;
  int q[$];
  int pk, done_at, obs_starts;
  bit seen_done;

  typedef struct {
    int sel;
    int n;
    int rwait;
    int lat;
    int exp_done_at;
    int exp_peak;
    int exp_stall;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_cs();
    return (ph == 1) && (iss < mn) && (q.size() < mx);
  endfunction

  task automatic check_outputs();
    chk("ap_idle", o_idle, ph == 0);
    chk("ap_done", o_done, ph == 2);
    chk("ap_ready", o_ready, ph == 2);
    chk("child_start", o_cstart, m_cs());
    chk("child_continue", o_cont, ph == 1);
    chk("issued_cnt", o_issued, iss);
    chk("done_cnt", o_donec, dc);
`ifdef HS_LAUNCH_PERF_EN
    chk("perf_busy", o_busy, busy);
    chk("perf_stall", o_stall, stall);
`else
    chk("perf_busy", o_busy, 0);
    chk("perf_stall", o_stall, 0);
`endif
    if (int'(o_issued) - int'(o_donec) > pk) pk = int'(o_issued) - int'(o_donec);
    if (o_done === 1'b1) begin
      seen_done = 1'b1;
      done_at   = cyc;
    end
  endtask

  task automatic model_update(input bit s, input int nr, input bit r, input bit d, input bit x);
    bit cs, dok;
    if (x) begin
      ph = 0; iss = 0; dc = 0; busy = 0; stall = 0; q.delete();
    end else if (ph == 0) begin
      if (s) begin
        ph = 1; mn = nr; iss = 0; dc = 0; busy = 0; stall = 0; q.delete();
      end
    end else if (ph == 1) begin
      cs  = m_cs();
      dok = d && (q.size() > 0);
      busy++;
      if (cs && !r) stall++;
      if (dok) begin
        void'(q.pop_front());
        dc++;
      end
      if (cs && r) begin
        iss++;
        q.push_back(cyc);
      end
      if (dc == mn) ph = 2;
    end else begin
      ph = 0;
    end
  endtask

  // One clock: check outputs, drive inputs, advance model at the edge.
  task automatic step(input bit s, input int nr, input bit r, input bit d, input bit x);
    check_outputs();
    ap_start = s; num_runs = CW'(nr); c_ready = r; c_done = d; ap_rst = x;
    if (o_cstart && r) obs_starts++;
    @(posedge ap_clk);
    model_update(s, nr, r, d, x);
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic switch_to(input int s);
    step(0, 0, 0, 0, 1);
    sel = s;
    mx  = (s == 1) ? 1 : 4;
  endtask

  task automatic finish_run();
    int guard;
    guard = 0;
    while (ph != 0 && guard < 100) begin
      step(0, 0, 1, q.size() > 0, 0);
      guard++;
    end
    chk("finish_bound", guard < 100, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, guard, wcnt;
    bit r, d, cs;
    if (v.sel != sel) switch_to(v.sel);
    step(0, 0, 0, 0, 0);
    pk = 0; seen_done = 0; obs_starts = 0; wcnt = 0; done_at = -1;
    t0 = cyc;
    step(1, v.n, 0, 0, 0);
    guard = 0;
    while (!(seen_done && ph == 0) && guard < 200) begin
      cs = m_cs();
      r  = (v.rwait == 0) ? 1'b1 : (cs && (wcnt >= v.rwait));
      d  = (q.size() > 0) && (q[0] + v.lat == cyc);
      if (cs && !r) wcnt++;
      else if (cs && r) wcnt = 0;
      step(0, 0, r, d, 0);
      guard++;
    end
    chk("vec_bound", guard < 200, 1);
    chk("vec_done_at", done_at - t0, v.exp_done_at);
    chk("vec_starts", obs_starts, v.n);
    chk("vec_peak", pk, v.exp_peak);
    chk("vec_issued_end", o_issued, v.n);
    chk("vec_done_end", o_donec, v.n);
`ifdef HS_LAUNCH_PERF_EN
    chk("vec_stall", o_stall, v.exp_stall);
`else
    chk("vec_stall", o_stall, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 1, n: 3, rwait: 0, lat: 5,  exp_done_at: 19, exp_peak: 1, exp_stall: 0};
    vecs[1] = '{sel: 0, n: 8, rwait: 0, lat: 10, exp_done_at: 26, exp_peak: 4, exp_stall: 0};
    vecs[2] = '{sel: 0, n: 0, rwait: 0, lat: 1,  exp_done_at: 2,  exp_peak: 0, exp_stall: 0};
    vecs[3] = '{sel: 0, n: 2, rwait: 3, lat: 2,  exp_done_at: 11, exp_peak: 1, exp_stall: 6};

    sel = 0; mx = 4; cyc = 0; ph = 0; mn = 0; iss = 0; dc = 0; busy = 0; stall = 0;
    pk = 0; seen_done = 0; obs_starts = 0; done_at = -1;
    ap_rst = 1'b1; ap_start = 1'b0; num_runs = '0; c_ready = 1'b0; c_done = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    chk("rst_idle", o_idle, 1);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_child_start", o_cstart, 0);
    chk("rst_continue", o_cont, 0);
    chk("rst_issued", o_issued, 0);
    chk("rst_donecnt", o_donec, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_stall", o_stall, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Start and done handshakes in the same cycle with two runs open.
    switch_to(0);
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pair_open", int'(o_issued) - int'(o_donec), 2);
    step(0, 0, 1, 1, 0);
    chk("pair_issued", o_issued, 3);
    chk("pair_donecnt", o_donec, 1);
    chk("pair_open_after", int'(o_issued) - int'(o_donec), 2);
    finish_run();

    // Reset with two runs open, then stray dones in IDLE and in RUN with nothing open.
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk("midrst_child_start", o_cstart, 0);
    chk("midrst_idle", o_idle, 1);
    chk("midrst_issued", o_issued, 0);
    chk("midrst_donecnt", o_donec, 0);
    step(0, 0, 0, 1, 0);
    chk("stray_idle_donecnt", o_donec, 0);
    chk("stray_idle_idle", o_idle, 1);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("stray_run_donecnt", o_donec, 0);
    chk("stray_run_start_held", o_cstart, 1);
    finish_run();

    // Random traffic: parent start noise (held through FIN), random ready/done, stray dones, resets.
    for (int k = 0; k < 1500; k++) begin
      bit r, d, s, x;
      if (ph == 0 && $urandom_range(0, 49) == 0) begin
        switch_to(int'($urandom_range(0, 1)));
      end else begin
        s = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
        d = ((q.size() > 0) && (q[0] < cyc) && ($urandom_range(0, 1) == 1)) ||
            ($urandom_range(0, 19) == 0);
        x = ($urandom_range(0, 299) == 0);
        step(s, int'($urandom_range(0, 9)), r, d, x);
      end
    end
    finish_run();
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
